// File: rtl/bus_cycle_ctrl.sv
// Bus-cycle sequencer: runs one core request as T1-T2-T3-(TW..)-T4 on the external bus,
// with a bounded wait-state counter that forces T4 with err on timeout.
module bus_cycle_ctrl #(
  parameter int unsigned MAX_WAIT = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_wr,
  input  logic [19:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  input  logic        ready,
  input  logic [15:0] data_in,
  output logic [19:0] Direction,
  output logic        RD_WR,
  output logic        ale,
  output logic        strb,
  output logic [15:0] data_out,
  output logic        data_oe,
  output logic        done,
  output logic        err,
  output logic [15:0] rdata
);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4} state_t;

  localparam logic [7:0] MAX_W = MAX_WAIT[7:0];

  state_t      state, state_nx;
  logic [7:0]  wait_cnt, wait_cnt_nx;
  logic [15:0] wdata_q, wdata_nx;
  logic [19:0] dir_nx;
  logic        rdwr_nx, ale_nx, strb_nx, data_oe_nx, done_nx, err_nx;
  logic [15:0] data_out_nx, rdata_nx;
  logic        to_t4, tmo;

  assign req_ready = (state == S_IDLE);

  // Outputs are loaded on the edge that enters a state, so they are valid for that whole state.
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    wdata_nx    = wdata_q;
    dir_nx      = Direction;
    rdwr_nx     = RD_WR;
    ale_nx      = 1'b0;
    strb_nx     = strb;
    data_out_nx = data_out;
    data_oe_nx  = data_oe;
    done_nx     = 1'b0;
    err_nx      = 1'b0;
    rdata_nx    = rdata;
    to_t4       = 1'b0;
    tmo         = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_nx    = S_T1;
          dir_nx      = req_addr;
          rdwr_nx     = req_wr;
          wdata_nx    = req_wdata;
          ale_nx      = 1'b1;
          wait_cnt_nx = 8'd0;
        end
      end
      S_T1: begin
        state_nx = S_T2;
        strb_nx  = 1'b1;
        if (RD_WR) begin
          data_oe_nx  = 1'b1;
          data_out_nx = wdata_q;
        end
      end
      S_T2: state_nx = S_T3;
      S_T3: begin
        if (ready) begin
          to_t4 = 1'b1;
          if (!RD_WR) rdata_nx = data_in;
        end else if (MAX_W == 8'd0) begin
          to_t4 = 1'b1;
          tmo   = 1'b1;
        end else begin
          state_nx    = S_TW;
          wait_cnt_nx = 8'd1;
        end
      end
      S_TW: begin
        if (ready) begin
          to_t4 = 1'b1;
          if (!RD_WR) rdata_nx = data_in;
        end else if (wait_cnt == MAX_W) begin
          to_t4 = 1'b1;
          tmo   = 1'b1;
        end else begin
          wait_cnt_nx = wait_cnt + 8'd1;
        end
      end
      S_T4:    state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (to_t4) begin
      state_nx    = S_T4;
      strb_nx     = 1'b0;
      data_oe_nx  = 1'b0;
      data_out_nx = 16'h0000;
      done_nx     = 1'b1;
      err_nx      = tmo;
      if (tmo && !RD_WR) rdata_nx = 16'hFFFF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= 8'd0;
      wdata_q   <= 16'h0000;
      Direction <= 20'h00000;
      RD_WR     <= 1'b0;
      ale       <= 1'b0;
      strb      <= 1'b0;
      data_out  <= 16'h0000;
      data_oe   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= 16'h0000;
    end else begin
      state     <= state_nx;
      wait_cnt  <= wait_cnt_nx;
      wdata_q   <= wdata_nx;
      Direction <= dir_nx;
      RD_WR     <= rdwr_nx;
      ale       <= ale_nx;
      strb      <= strb_nx;
      data_out  <= data_out_nx;
      data_oe   <= data_oe_nx;
      done      <= done_nx;
      err       <= err_nx;
      rdata     <= rdata_nx;
    end
  end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Self-checking bench for bus_cycle_ctrl: two instances (MAX_WAIT 7 and 2) share the bus inputs;
// each transaction is predicted from its ready pattern (first ready sample vs. wait limit).
module tb_bus_cycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  req;
  logic        req_wr;
  logic [19:0] req_addr;
  logic [15:0] req_wdata;
  logic        ready;
  logic [15:0] data_in;

  logic [1:0]        req_ready_s, rd_wr_s, ale_s, strb_s, data_oe_s, done_s, err_s;
  logic [1:0][19:0]  dir_s;
  logic [1:0][15:0]  data_out_s, rdata_s;

  int errors = 0;
  int checks = 0;
  logic [15:0] rdata_exp [2];

  bus_cycle_ctrl #(.MAX_WAIT(7)) u_dut7 (
    .clk(clk), .reset(reset), .req(req[0]), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready_s[0]), .ready(ready), .data_in(data_in),
    .Direction(dir_s[0]), .RD_WR(rd_wr_s[0]), .ale(ale_s[0]), .strb(strb_s[0]),
    .data_out(data_out_s[0]), .data_oe(data_oe_s[0]), .done(done_s[0]), .err(err_s[0]),
    .rdata(rdata_s[0]));

  bus_cycle_ctrl #(.MAX_WAIT(2)) u_dut2 (
    .clk(clk), .reset(reset), .req(req[1]), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready_s[1]), .ready(ready), .data_in(data_in),
    .Direction(dir_s[1]), .RD_WR(rd_wr_s[1]), .ale(ale_s[1]), .strb(strb_s[1]),
    .data_out(data_out_s[1]), .data_oe(data_oe_s[1]), .done(done_s[1]), .err(err_s[1]),
    .rdata(rdata_s[1]));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Control vector order: ale, strb, data_oe, done, err, req_ready
  task automatic run_txn(input int sel, input logic wr, input logic [19:0] addr,
                         input logic [15:0] wd, input logic [15:0] dat,
                         input logic [15:0] mask, input string name);
    int mw, i, d;
    logic tmo;
    logic [5:0] ctl_exp, ctl_act;
    mw = (sel == 1) ? 2 : 7;
    i = 0;
    while (i < 16 && !mask[i]) i++;
    tmo = (i > mw);
    d = tmo ? 4 + mw : 4 + i;
    @(negedge clk);
    checks++;
    if (req_ready_s[sel] !== 1'b1) begin
      errors++;
      $display("FAIL %s pre_ready got=%b exp=1", name, req_ready_s[sel]);
    end
    req[sel] = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd;
    ready = 1'($urandom); data_in = 16'($urandom);
    @(posedge clk);
    for (int n = 1; n <= d + 1; n++) begin
      @(negedge clk);
      if (n == 1) begin
        req[sel] = 1'b0; req_wr = 1'($urandom);
        req_addr = 20'($urandom); req_wdata = 16'($urandom);
      end
      if (n == d && !wr) rdata_exp[sel] = tmo ? 16'hFFFF : dat;
      ctl_exp = {n == 1, n >= 2 && n < d, wr && n >= 2 && n < d, n == d, n == d && tmo, n > d};
      ctl_act = {ale_s[sel], strb_s[sel], data_oe_s[sel], done_s[sel], err_s[sel], req_ready_s[sel]};
      checks++;
      if (ctl_act !== ctl_exp) begin
        errors++;
        $display("FAIL %s ctl n=%0d got=%b exp=%b", name, n, ctl_act, ctl_exp);
      end
      checks++;
      if ({dir_s[sel], rd_wr_s[sel]} !== {addr, wr}) begin
        errors++;
        $display("FAIL %s addr n=%0d got=%h/%b exp=%h/%b", name, n, dir_s[sel], rd_wr_s[sel], addr, wr);
      end
      if (ctl_exp[3]) begin
        checks++;
        if (data_out_s[sel] !== wd) begin
          errors++;
          $display("FAIL %s data_out n=%0d got=%h exp=%h", name, n, data_out_s[sel], wd);
        end
      end
      checks++;
      if (rdata_s[sel] !== rdata_exp[sel]) begin
        errors++;
        $display("FAIL %s rdata n=%0d got=%h exp=%h", name, n, rdata_s[sel], rdata_exp[sel]);
      end
      ready   = (n >= 3 && n < d) ? mask[n-3] : 1'($urandom);
      data_in = (n == d - 1) ? dat : 16'($urandom);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req = 2'b00; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    ready = 1'b0; data_in = '0;
    rdata_exp[0] = 16'h0; rdata_exp[1] = 16'h0;
    #13;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if ({dir_s[s], rd_wr_s[s], ale_s[s], strb_s[s], data_out_s[s], data_oe_s[s],
           done_s[s], err_s[s], rdata_s[s], req_ready_s[s]} !== {74'h0, 1'b1}) begin
        errors++;
        $display("FAIL por_values dut=%0d dir=%h ale=%b strb=%b oe=%b done=%b err=%b rdata=%h rr=%b exp zeros rr=1",
                 s, dir_s[s], ale_s[s], strb_s[s], data_oe_s[s], done_s[s], err_s[s], rdata_s[s], req_ready_s[s]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_abort;
    logic [19:0] a1, a2;
    a1 = 20'($urandom) | 20'h1;
    a2 = 20'($urandom) | 20'h2;
    @(negedge clk);
    req[0] = 1'b1; req_wr = 1'b0; req_addr = a1; ready = 1'b0;
    @(posedge clk);
    @(negedge clk); req[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({dir_s[0], rd_wr_s[0], ale_s[0], strb_s[0], data_out_s[0], data_oe_s[0],
         done_s[0], err_s[0], rdata_s[0], req_ready_s[0]} !== {74'h0, 1'b1}) begin
      errors++;
      $display("FAIL abort_async dir=%h strb=%b done=%b err=%b rdata=%h rr=%b exp zeros rr=1",
               dir_s[0], strb_s[0], done_s[0], err_s[0], rdata_s[0], req_ready_s[0]);
    end
    rdata_exp[0] = 16'h0; rdata_exp[1] = 16'h0;
    req[0] = 1'b1; req_addr = a2; ready = 1'b1; data_in = 16'h5AC3;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (done_s[0] !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_done c=%0d got=%b exp=0", c, done_s[0]);
      end
    end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    checks++;
    if ({ale_s[0], dir_s[0], req_ready_s[0]} !== {1'b1, a2, 1'b0}) begin
      errors++;
      $display("FAIL release_accept got ale=%b dir=%h rr=%b exp ale=1 dir=%h rr=0",
               ale_s[0], dir_s[0], req_ready_s[0], a2);
    end
    for (int n = 2; n <= 5; n++) begin
      @(negedge clk);
      checks++;
      if (done_s[0] !== (n == 4)) begin
        errors++;
        $display("FAIL release_done n=%0d got=%b exp=%b", n, done_s[0], n == 4);
      end
    end
    rdata_exp[0] = 16'h5AC3;
    checks++;
    if (rdata_s[0] !== rdata_exp[0]) begin
      errors++;
      $display("FAIL release_rdata got=%h exp=%h", rdata_s[0], rdata_exp[0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [19:0] a, b;
    logic [15:0] da, wb;
    logic [5:0] ctl_exp, ctl_act;
    a = 20'($urandom); b = ~a; da = 16'($urandom); wb = 16'($urandom);
    @(negedge clk);
    req[0] = 1'b1; req_wr = 1'b0; req_addr = a; ready = 1'b1; data_in = da;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) begin req_wr = 1'b1; req_addr = b; req_wdata = wb; end
      if (n == 6) req[0] = 1'b0;
      if (n == 4) rdata_exp[0] = da;
      ctl_exp = {n == 1 || n == 6, (n >= 2 && n <= 3) || (n >= 7 && n <= 8), n >= 7 && n <= 8,
                 n == 4 || n == 9, 1'b0, n == 5 || n == 10};
      ctl_act = {ale_s[0], strb_s[0], data_oe_s[0], done_s[0], err_s[0], req_ready_s[0]};
      checks++;
      if (ctl_act !== ctl_exp) begin
        errors++;
        $display("FAIL b2b ctl n=%0d got=%b exp=%b", n, ctl_act, ctl_exp);
      end
      checks++;
      if ({dir_s[0], rd_wr_s[0]} !== ((n < 6) ? {a, 1'b0} : {b, 1'b1})) begin
        errors++;
        $display("FAIL b2b addr n=%0d got=%h/%b", n, dir_s[0], rd_wr_s[0]);
      end
      checks++;
      if (rdata_s[0] !== rdata_exp[0]) begin
        errors++;
        $display("FAIL b2b rdata n=%0d got=%h exp=%h", n, rdata_s[0], rdata_exp[0]);
      end
    end
  endtask

  task automatic test_random;
    int sel, k;
    logic [15:0] mask;
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 1);
      k = $urandom_range(0, 9);
      mask = (k == 9) ? 16'h0 : ((16'($urandom) << (k + 1)) | (16'h1 << k));
      run_txn(sel, 1'($urandom), 20'($urandom), 16'($urandom), 16'($urandom), mask, "random");
    end
  endtask

  initial begin
    test_reset();
    run_txn(0, 1'b0, 20'hF1234, 16'h0000, 16'hBEEF, 16'h0001, "zero_wait_read");
    run_txn(0, 1'b1, 20'h00010, 16'hA55A, 16'h1234, 16'h0001, "zero_wait_write");
    run_txn(0, 1'b0, 20'h3C3C3, 16'h0000, 16'h7E81, 16'h0008, "wait3");
    run_txn(1, 1'b0, 20'hABCDE, 16'h0000, 16'h4321, 16'h0000, "timeout_read");
    run_txn(1, 1'b0, 20'h12345, 16'h0000, 16'h9999, 16'h0004, "ready_at_limit");
    run_txn(0, 1'b1, 20'h0F0F0, 16'hC0DE, 16'h2222, 16'h0000, "timeout_write");
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
